l2g_clk_div_gen: RTL
====================

// Module: l2g_clk_div_gen
// PURPOSE
//  Fabric clock source for logic-to-global routing tests. Divides the input clock into a
//  registered, glitch-free div_clk_o that drives a global clock net and its flop chain.
//  Also supplies an LFSR data bit, pat_o, for the first flop of that chain.
//  pat_o changes only on div_clk_o falling edges, so it is stable at every rising edge.
// PARAMETERS
//  DIV_W   8        width of div_ratio; phase length = div_ratio+1 clk cycles
//  SEED    16'hACE1 LFSR reset value (must be non-zero)
// PORTS
//  clk         in   1      input clock; all logic on posedge
//  rst_n       in   1      asynchronous, active-low reset
//  en          in   1      run request; level-sensitive
//  div_ratio   in   DIV_W  half-period minus 1; sampled only on IDLE->RUN
//  div_clk_o   in/out: out 1  divided clock, driven directly from a flop
//  running_o   out  1      high in RUN and STOP
//  rise_o      out  1      1-cycle pulse coincident with div_clk_o going 0->1
//  pat_o       out  1      LFSR bit 0
//  edge_cnt_o  out  16     count of div_clk_o rising edges; wraps FFFF->0000
// BEHAVIOUR
//  Reset values (rst_n low, asynchronous):
//   state=IDLE, div_clk_o=0, running_o=0, rise_o=0, cnt=0, ratio_q=0,
//   lfsr=SEED, pat_o=SEED[0], edge_cnt_o=0.
//  Reset asserted mid-phase forces div_clk_o low at once. This is the only permitted short phase.
//  States:
//   IDLE: div_clk_o=0.
//    - en=1 -> RUN next edge, ratio_q<=div_ratio, cnt<=0.
//   RUN:
//    - Each edge: if cnt==ratio_q, toggle div_clk_o and set cnt<=0; else cnt<=cnt+1.
//    - en=0 -> STOP; counting continues unchanged.
//   STOP:
//    - div_clk_o=0 -> IDLE next edge.
//    - div_clk_o=1 -> keep counting; at the terminal count, toggle to 0 and enter IDLE on that edge.
//    - en ignored in STOP. If en is still high in IDLE, RUN follows one edge later.
//  Timing:
//   - Edge that samples en=1 in IDLE is E0. div_clk_o rises at E(ratio_q+1) after E0.
//   - Each phase is exactly ratio_q+1 cycles; period is 2*(ratio_q+1).
//   - ratio_q=0 gives divide-by-2.
//  Glitch-freedom:
//   - A high phase is never shortened. Stop always completes the current high phase.
//   - A low phase is never shorter than ratio_q+1 cycles: a restart from IDLE recounts from 0.
//  div_ratio changes while running_o=1 have no effect until the next IDLE->RUN.
//  On the edge where div_clk_o goes 0->1:
//   - rise_o=1 for that cycle.
//   - edge_cnt_o<=edge_cnt_o+1, modulo 2^16.
//  On the edge where div_clk_o goes 1->0 (including the final fall in STOP):
//   - LFSR advances.
//   - Fibonacci step: fb=lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5]; lfsr<={fb,lfsr[15:1]}.
//  pat_o=lfsr[0] is registered and is never updated on a rising edge of div_clk_o.
// TESTING
//  T1: ratio=0, en=1 -> div_clk_o toggles every cycle; rise_o every 2nd cycle; edge_cnt_o=5 after 5 rises.
//  T2: ratio=3 -> first rise 4 cycles after E0, then 4 high / 4 low; running_o=1 throughout.
//  T3: ratio=3, drop en in 2nd cycle of a high phase -> high lasts the full 4 cycles, falls, IDLE; running_o=0 next cycle.
//  T4: ratio=3 running, change div_ratio to 7 -> period stays 8. Stop, restart -> period 16.
//  T5: after reset, pat_o after falls 0..5 = 1,0,0,0,0,1; lfsr = ACE1,5670,AB38,559C,2ACE,1567.
//  T6: rst_n low mid high phase -> all outputs at reset values immediately. Release with en=1 -> clean restart from E0 timing.
//  T7: force edge_cnt_o to FFFF, one more rise -> 0000.

Source files
------------

// File: rtl/l2g_clk_div_gen.sv
// Glitch-free registered clock divider with a rising-edge counter and an LFSR pattern bit.
// The divided clock, pulse and counter outputs are registered; there is no backpressure, and en is a level run request.
module l2g_clk_div_gen #(
    parameter int          DIV_W = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             div_clk_o,
    output logic             running_o,
    output logic             rise_o,
    output logic             pat_o,
    output logic [15:0]      edge_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic             div_q, div_d;
    logic             running_q, running_d;
    logic             rise_q, rise_d;
    logic             fall;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic             tc;
    logic             fb;

    assign tc = (cnt_q == ratio_q);
    assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        div_d      = div_q;
        rise_d     = 1'b0;
        fall       = 1'b0;
        lfsr_d     = lfsr_q;
        edge_cnt_d = edge_cnt_q;

        unique case (state_q)
            IDLE: begin
                div_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                    ratio_d = div_ratio;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (tc) begin
                    div_d = ~div_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!en) state_d = STOP;
            end
            STOP: begin
                // A high phase in progress always runs to its terminal count.
                if (!div_q) begin
                    state_d = IDLE;
                end else if (tc) begin
                    div_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = 1'b0;
            end
        endcase

        rise_d = ~div_q & div_d;
        fall   = div_q & ~div_d;
        if (fall) lfsr_d = {fb, lfsr_q[15:1]};
        if (rise_d) edge_cnt_d = edge_cnt_q + 16'd1;
        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ratio_q    <= '0;
            div_q      <= 1'b0;
            running_q  <= 1'b0;
            rise_q     <= 1'b0;
            lfsr_q     <= SEED;
            edge_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            div_q      <= div_d;
            running_q  <= running_d;
            rise_q     <= rise_d;
            lfsr_q     <= lfsr_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign div_clk_o  = div_q;
    assign running_o  = running_q;
    assign rise_o     = rise_q;
    assign pat_o      = lfsr_q[0];
    assign edge_cnt_o = edge_cnt_q;

endmodule
